vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 800, SHALL set visible pixels per line.
REQ-002 Parameter H_FRONT, default 56, SHALL set the horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 120, SHALL set the horizontal sync width in clocks.
REQ-004 Parameter H_BACK, default 64, SHALL set the horizontal back porch in clocks.
REQ-005 Parameter V_VISIBLE, default 600, SHALL set visible lines per frame.
REQ-006 Parameter V_FRONT, default 37, SHALL set the vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 6, SHALL set the vertical sync width in lines.
REQ-008 Parameter V_BACK, default 23, SHALL set the vertical back porch in lines.
REQ-009 Parameter PIX_LATENCY, default 1, range 1..4, SHALL set the downstream pixel-generator latency in clocks.
REQ-010 clk  input  1  SHALL be the pixel clock (50 MHz, 800x600 at 72 Hz); all logic rising-edge.
REQ-011 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-012 PIXEL  input  3  SHALL carry the {R,G,B} colour returned by the downstream text stage, PIX_LATENCY clocks after PIXEL_H/PIXEL_V.
REQ-013 PIXEL_H  output  11  SHALL be the registered horizontal counter, fed to the text stage.
REQ-014 PIXEL_V  output  11  SHALL be the registered vertical counter, fed to the text stage.
REQ-015 FRAME_START  output  1  SHALL be a one-clock pulse while PIXEL_H=0 and PIXEL_V=0.
REQ-016 VGA_HS, VGA_VS  output  1 each  SHALL be active-high sync outputs, pixel-aligned.
REQ-017 VGA_R, VGA_G, VGA_B  output  1 each  SHALL be the blanked, pixel-aligned colour outputs.

Function
REQ-018 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (1040) and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (666) SHALL define the counter periods.
REQ-019 PIXEL_H SHALL increment every clock and wrap from H_TOTAL-1 to 0.
REQ-020 PIXEL_V SHALL increment only in the clock where PIXEL_H wraps, and SHALL wrap from V_TOTAL-1 to 0 in that same clock.
REQ-021 Raw display enable SHALL be (PIXEL_H < H_VISIBLE) and (PIXEL_V < V_VISIBLE).
REQ-022 Raw HS SHALL be high for PIXEL_H in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [856, 975].
REQ-023 Raw VS SHALL be high for PIXEL_V in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [637, 642], for whole lines.
REQ-024 Raw enable, HS and VS SHALL pass through a PIX_LATENCY-stage shift register and then one output register.
REQ-025 Net result: the counter value at clock t SHALL appear on VGA_HS/VGA_VS/VGA_R/G/B at clock t+PIX_LATENCY+1.
REQ-026 The output register SHALL load {VGA_R,VGA_G,VGA_B} = PIXEL when the delayed enable is high, else 3'b000.
REQ-027 FRAME_START SHALL be registered and coincident with PIXEL_H=0, PIXEL_V=0; it SHALL NOT be delayed.
REQ-028 Counter arithmetic SHALL be 11-bit unsigned; no parameter set SHALL allow H_TOTAL or V_TOTAL above 2047.

Reset
REQ-029 While rst_n=0: PIXEL_H=0, PIXEL_V=0, FRAME_START=0, VGA_HS=0, VGA_VS=0, VGA_R/G/B=0, and all delay stages cleared.
REQ-030 Reset asserted mid-line or mid-frame SHALL clear state immediately, without waiting for a clock edge.
REQ-031 The first clock after rst_n rises SHALL present PIXEL_H=0, PIXEL_V=0 with FRAME_START=1; PIXEL_H=1 SHALL follow on the next clock.

Configuration
REQ-032 Macro VGA_COLORBAR_EN, when defined, SHALL replace PIXEL at the output mux with PIXEL_H[9:7] delayed PIX_LATENCY clocks; the PIXEL input SHALL then be ignored.
REQ-033 Without VGA_COLORBAR_EN, the PIXEL input SHALL be used as in REQ-026.

Verification
REQ-034 Release reset, run 1040 clocks -> PIXEL_H goes 0..1039 then 0; PIXEL_V steps 0->1 in the same clock as the wrap.
REQ-035 Run one full frame (692640 clocks) -> exactly one FRAME_START pulse per frame; PIXEL_V wraps 665->0.
REQ-036 PIX_LATENCY=1, hold PIXEL=3'b101 -> VGA_HS high for exactly 120 clocks starting 2 clocks after PIXEL_H=856; RGB=101 at counter (0,0)+2 clocks and 000 at counter (800,0)+2 clocks.
REQ-037 Track lines -> VGA_VS high for exactly 6 lines, PIXEL_V 637..642 (each +2 clocks); RGB=000 for all of lines 600..665.
REQ-038 Assert rst_n=0 at PIXEL_H=400, PIXEL_V=300, no clock edge -> all outputs 0 immediately; after release, sequence restarts at (0,0) with FRAME_START.
REQ-039 With VGA_COLORBAR_EN defined -> VGA_R/G/B=3'b000 for PIXEL_H 0..127 and 3'b001 for 128..255 (shifted by PIX_LATENCY+1 clocks), independent of PIXEL.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters, delay-matched sync and blanked colour.
// Optional build macro VGA_COLORBAR_EN drives a test colour bar from the horizontal counter instead of PIXEL.
module vga_timing_gen #(
    parameter int H_VISIBLE   = 800,
    parameter int H_FRONT     = 56,
    parameter int H_SYNC      = 120,
    parameter int H_BACK      = 64,
    parameter int V_VISIBLE   = 600,
    parameter int V_FRONT     = 37,
    parameter int V_SYNC      = 6,
    parameter int V_BACK      = 23,
    parameter int PIX_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  PIXEL,
    output logic [10:0] PIXEL_H,
    output logic [10:0] PIXEL_V,
    output logic        FRAME_START,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_DE_END    = 11'(H_VISIBLE);
    localparam logic [10:0] V_DE_END    = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    // Counters are 11 bits wide; reject raster sizes that would not fit.
    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
        $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 2047");
    end
    if (PIX_LATENCY < 1 || PIX_LATENCY > 4) begin : g_bad_latency
        $fatal(1, "vga_timing_gen: PIX_LATENCY must be in 1..4");
    end

`ifdef VGA_COLORBAR_EN
    localparam int STAGE_W = 6;
`else
    localparam int STAGE_W = 3;
`endif

    logic        run_reg;
    logic        h_wrap;
    logic [10:0] h_next;
    logic [10:0] v_next;

    always_comb begin
        h_wrap = (PIXEL_H == H_LAST);
        h_next = h_wrap ? 11'd0 : PIXEL_H + 11'd1;
        v_next = PIXEL_V;
        if (h_wrap) begin
            v_next = (PIXEL_V == V_LAST) ? 11'd0 : PIXEL_V + 11'd1;
        end
    end

    // The first edge after reset only raises run_reg and FRAME_START, so (0,0) is presented with the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg     <= 1'b0;
            PIXEL_H     <= 11'd0;
            PIXEL_V     <= 11'd0;
            FRAME_START <= 1'b0;
        end else if (!run_reg) begin
            run_reg     <= 1'b1;
            FRAME_START <= 1'b1;
        end else begin
            PIXEL_H     <= h_next;
            PIXEL_V     <= v_next;
            FRAME_START <= (h_next == 11'd0) && (v_next == 11'd0);
        end
    end

    // Raw timing is masked until counting starts so the idle counter value never reaches the outputs.
    logic de_raw;
    logic hs_raw;
    logic vs_raw;
    logic [STAGE_W-1:0] stage_in;

    always_comb begin
        de_raw = run_reg && (PIXEL_H < H_DE_END) && (PIXEL_V < V_DE_END);
        hs_raw = run_reg && (PIXEL_H >= H_SYNC_BEG) && (PIXEL_H < H_SYNC_END);
        vs_raw = run_reg && (PIXEL_V >= V_SYNC_BEG) && (PIXEL_V < V_SYNC_END);
`ifdef VGA_COLORBAR_EN
        stage_in = {PIXEL_H[9:7], vs_raw, hs_raw, de_raw};
`else
        stage_in = {vs_raw, hs_raw, de_raw};
`endif
    end

    logic [PIX_LATENCY-1:0][STAGE_W-1:0] pipe_reg;
    logic [PIX_LATENCY-1:0][STAGE_W-1:0] pipe_next;

    for (genvar gi = 0; gi < PIX_LATENCY; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign pipe_next[gi] = stage_in;
        end else begin : g_rest
            assign pipe_next[gi] = pipe_reg[gi-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    logic [STAGE_W-1:0] tail;
    logic [2:0]         colour_src;

    always_comb begin
        tail = pipe_reg[PIX_LATENCY-1];
`ifdef VGA_COLORBAR_EN
        colour_src = tail[5:3];
`else
        colour_src = PIXEL;
`endif
    end

    // Output register: PIXEL lines up with the tail stage because the text stage has the same latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            VGA_HS <= 1'b0;
            VGA_VS <= 1'b0;
            {VGA_R, VGA_G, VGA_B} <= 3'b000;
        end else begin
            VGA_HS <= tail[1];
            VGA_VS <= tail[2];
            {VGA_R, VGA_G, VGA_B} <= tail[0] ? colour_src : 3'b000;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-pixel bench for vga_timing_gen on a reduced raster (55 x 29 clocks, latency 2),
// checked every cycle against an arithmetic raster model plus literal anchor points.
module tb_vga_timing_gen;

    localparam int HV  = 40;
    localparam int HF  = 4;
    localparam int HSW = 6;
    localparam int HB  = 5;
    localparam int VV  = 20;
    localparam int VF  = 3;
    localparam int VSW = 2;
    localparam int VB  = 4;
    localparam int LAT = 2;
    localparam int HT  = HV + HF + HSW + HB;
    localparam int VT  = VV + VF + VSW + VB;

    logic        clk;
    logic        rst_n;
    logic [2:0]  PIXEL;
    logic [10:0] PIXEL_H;
    logic [10:0] PIXEL_V;
    logic        FRAME_START;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_R;
    logic        VGA_G;
    logic        VGA_B;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .PIX_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .PIXEL(PIXEL),
        .PIXEL_H(PIXEL_H),
        .PIXEL_V(PIXEL_V),
        .FRAME_START(FRAME_START),
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = -1;
    bit run_chk  = 1'b0;
    bit phase1   = 1'b0;
    int hs_cnt   = 0;
    int fs_cnt   = 0;
    logic [2:0] pix_hist [0:4095];

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, k, act, exp);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_h"},  cyc, int'(PIXEL_H), 0);
        chk({name, "_v"},  cyc, int'(PIXEL_V), 0);
        chk({name, "_fs"}, cyc, int'(FRAME_START), 0);
        chk({name, "_hs"}, cyc, int'(VGA_HS), 0);
        chk({name, "_vs"}, cyc, int'(VGA_VS), 0);
        chk({name, "_rgb"}, cyc, int'({VGA_R, VGA_G, VGA_B}), 0);
    endtask

    // Raster model: cycle k after reset shows counter (k mod HT, k/HT mod VT); the
    // outputs in cycle k describe counter cycle k-LAT-1 and are zero before that exists.
    task automatic compare_cycle(input int k);
        int h, v, j, hj, vj;
        bit de, hs, vs;
        logic [2:0] src, rgb_exp;
        h = k % HT;
        v = (k / HT) % VT;
        chk("pixel_h", k, int'(PIXEL_H), h);
        chk("pixel_v", k, int'(PIXEL_V), v);
        chk("frame_start", k, int'(FRAME_START), int'(h == 0 && v == 0));
        de = 1'b0; hs = 1'b0; vs = 1'b0; src = 3'b000;
        if (k >= LAT + 1) begin
            j  = k - LAT - 1;
            hj = j % HT;
            vj = (j / HT) % VT;
            de = (hj < HV) && (vj < VV);
            hs = (hj >= HV + HF) && (hj < HV + HF + HSW);
            vs = (vj >= VV + VF) && (vj < VV + VF + VSW);
`ifdef VGA_COLORBAR_EN
            src = 3'((hj >> 7) & 7);
`else
            src = pix_hist[k-1];
`endif
        end
        rgb_exp = de ? src : 3'b000;
        chk("vga_hs", k, int'(VGA_HS), int'(hs));
        chk("vga_vs", k, int'(VGA_VS), int'(vs));
        chk("vga_rgb", k, int'({VGA_R, VGA_G, VGA_B}), int'(rgb_exp));

        if (phase1) begin
            hs_cnt += int'(VGA_HS);
            fs_cnt += int'(FRAME_START);
            // Hand-computed anchors for this raster (HS at h 44..49, VS at lines 23..24, +3 clocks).
            case (k)
                0:    chk("lit_fs0", k, int'(FRAME_START), 1);
                1:    chk("lit_h1", k, int'(PIXEL_H), 1);
                54:   chk("lit_h54", k, int'(PIXEL_H), 54);
                55:   chk("lit_v_step", k, int'({PIXEL_V, PIXEL_H}), int'({11'd1, 11'd0}));
                46:   chk("lit_hs_pre", k, int'(VGA_HS), 0);
                47:   chk("lit_hs_first", k, int'(VGA_HS), 1);
                52:   chk("lit_hs_last", k, int'(VGA_HS), 1);
                53:   chk("lit_hs_post", k, int'(VGA_HS), 0);
`ifndef VGA_COLORBAR_EN
                3:    chk("lit_rgb_00", k, int'({VGA_R, VGA_G, VGA_B}), int'(pix_hist[2]));
`endif
                43:   chk("lit_rgb_blank_h", k, int'({VGA_R, VGA_G, VGA_B}), 0);
                1103: chk("lit_rgb_blank_v", k, int'({VGA_R, VGA_G, VGA_B}), 0);
                1267: chk("lit_vs_pre", k, int'(VGA_VS), 0);
                1268: chk("lit_vs_first", k, int'(VGA_VS), 1);
                1377: chk("lit_vs_last", k, int'(VGA_VS), 1);
                1378: chk("lit_vs_post", k, int'(VGA_VS), 0);
                1594: chk("lit_v_last", k, int'({PIXEL_V, PIXEL_H}), int'({11'd28, 11'd54}));
                1595: chk("lit_v_wrap", k, int'({FRAME_START, PIXEL_V}), int'({1'b1, 11'd0}));
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (run_chk && cyc >= 0) compare_cycle(cyc);
    end

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            PIXEL = 3'($urandom_range(0, 7));
            pix_hist[cyc] = PIXEL;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        PIXEL = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_state");
        $display("reset: outputs checked while rst_n=0");

        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        cyc     = -1;
        phase1  = 1'b1;
        run_chk = 1'b1;
        run_cycles(3600);
        @(negedge clk);
        #1;
        phase1 = 1'b0;
        chk("frame_pulses", cyc, fs_cnt, 3);
        chk("hs_high_clocks", cyc, hs_cnt, 390);
        $display("run: %0d cycles, frame_start pulses=%0d hs clocks=%0d", cyc + 1, fs_cnt, hs_cnt);

        // Mid-frame asynchronous reset between clock edges (counter at h=24, v=7).
        run_chk = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk_all_zero("async_reset");
        $display("async reset: asserted mid-frame at cycle %0d", cyc);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("held_reset");

        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        cyc     = -1;
        run_chk = 1'b1;
        run_cycles(1700);
        @(negedge clk);
        #1;
        run_chk = 1'b0;
        $display("restart: %0d cycles after second reset release", cyc + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
